// File: rtl/light_serialiser_pkg.sv
// Shared definitions for the RGB light transmit path: state encoding, default
// WS2812 timing at 100 MHz, and the RGB -> GRB wire-order reorder.
package light_serialiser_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SEND  = 2'd1,
        ST_LATCH = 2'd2
    } state_t;

    localparam int DEF_TBIT   = 125;
    localparam int DEF_T0H    = 40;
    localparam int DEF_T1H    = 80;
    localparam int DEF_TRESET = 5000;

    // LEDs expect green first on the wire; the selector produces {R,G,B}.
    function automatic logic [23:0] rgb_to_grb(input logic [23:0] rgb);
        return {rgb[15:8], rgb[23:16], rgb[7:0]};
    endfunction

endpackage

// File: rtl/light_serialiser.sv
// Single-wire WS2812-style serialiser: one 24-bit colour per handshake, MSB-first
// pulse-width coding, seamless chaining, and a low latch period after each burst.
module light_serialiser
    import light_serialiser_pkg::*;
#(
    parameter int TBIT   = DEF_TBIT,
    parameter int T0H    = DEF_T0H,
    parameter int T1H    = DEF_T1H,
    parameter int TRESET = DEF_TRESET
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [23:0] colour,
    input  logic        valid,
    output logic        ready,
    output logic        dout,
    output logic        busy
);

    if (!(T0H > 0 && T0H < T1H && T1H < TBIT && TRESET >= TBIT)) begin : g_bad_timing
        $error("light_serialiser: need 0 < T0H < T1H < TBIT and TRESET >= TBIT");
    end

    localparam int CW = $clog2(TRESET);
    localparam logic [CW-1:0] BIT_LAST   = CW'(TBIT - 1);
    localparam logic [CW-1:0] LATCH_LAST = CW'(TRESET - 1);
    localparam logic [CW-1:0] T0H_C      = CW'(T0H);
    localparam logic [CW-1:0] T1H_C      = CW'(T1H);

    state_t          r_state, w_state_nxt;
    logic [CW-1:0]   r_cnt, w_cnt_nxt;
    logic [4:0]      r_bit_idx, w_bit_idx_nxt;
    logic [23:0]     r_shift, w_shift_nxt;
    logic            r_dout, w_dout_nxt;
    logic            w_bit_end, w_frame_end, w_accept;

    assign w_bit_end   = (r_cnt == BIT_LAST);
    assign w_frame_end = w_bit_end && (r_bit_idx == 5'd23);
    assign ready       = (r_state == ST_IDLE) || ((r_state == ST_SEND) && w_frame_end);
    assign w_accept    = valid && ready;
    assign busy        = (r_state != ST_IDLE);
    assign dout        = r_dout;

    always_comb begin
        w_state_nxt   = r_state;
        w_cnt_nxt     = r_cnt;
        w_bit_idx_nxt = r_bit_idx;
        w_shift_nxt   = r_shift;
        case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
                    w_state_nxt   = ST_SEND;
                    w_cnt_nxt     = '0;
                    w_bit_idx_nxt = 5'd0;
                    w_shift_nxt   = rgb_to_grb(colour);
                end
            end
            ST_SEND: begin
                if (w_frame_end) begin
                    w_cnt_nxt     = '0;
                    w_bit_idx_nxt = 5'd0;
                    if (w_accept) begin
                        w_shift_nxt = rgb_to_grb(colour);
                    end else begin
                        w_state_nxt = ST_LATCH;
                        w_shift_nxt = {r_shift[22:0], 1'b0};
                    end
                end else if (w_bit_end) begin
                    w_cnt_nxt     = '0;
                    w_bit_idx_nxt = r_bit_idx + 5'd1;
                    w_shift_nxt   = {r_shift[22:0], 1'b0};
                end else begin
                    w_cnt_nxt = r_cnt + CW'(1);
                end
            end
            ST_LATCH: begin
                if (r_cnt == LATCH_LAST) begin
                    w_state_nxt = ST_IDLE;
                    w_cnt_nxt   = '0;
                end else begin
                    w_cnt_nxt = r_cnt + CW'(1);
                end
            end
            default: begin
                w_state_nxt = ST_LATCH;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    // dout is registered from the next-state view so the first bit starts right after accept.
    assign w_dout_nxt = (w_state_nxt == ST_SEND) &&
                        (w_cnt_nxt < (w_shift_nxt[23] ? T1H_C : T0H_C));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state   <= ST_LATCH;
            r_cnt     <= '0;
            r_bit_idx <= 5'd0;
            r_shift   <= 24'd0;
            r_dout    <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_cnt     <= w_cnt_nxt;
            r_bit_idx <= w_bit_idx_nxt;
            r_shift   <= w_shift_nxt;
            r_dout    <= w_dout_nxt;
        end
    end

endmodule

// File: tb/tb_light_serialiser.sv
// Directed and table-driven bench for light_serialiser: decodes dout pulse widths
// per bit and checks framing, handshake timing and latch length.
module tb_light_serialiser;

    localparam int TBIT   = 10;
    localparam int T0H    = 3;
    localparam int T1H    = 7;
    localparam int TRESET = 20;
    localparam logic [TBIT-1:0] PAT1 = 10'b1111111000;
    localparam logic [TBIT-1:0] PAT0 = 10'b1110000000;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [23:0] colour = 24'd0;
    logic        valid = 1'b0;
    logic        ready, dout, busy;

    int n_pass  = 0;
    int n_total = 0;

    typedef struct {
        logic [23:0] col;
        logic [23:0] grb;
    } vec_t;
    vec_t vecs[6];

    light_serialiser #(.TBIT(TBIT), .T0H(T0H), .T1H(T1H), .TRESET(TRESET)) dut (
        .clk    (clk),
        .rst    (rst),
        .colour (colour),
        .valid  (valid),
        .ready  (ready),
        .dout   (dout),
        .busy   (busy)
    );

    always #5 clk = ~clk;

    function automatic logic [23:0] model_grb(input logic [23:0] c);
        return {c[15:8], c[23:16], c[7:0]};
    endfunction

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    endtask

    task automatic wait_ready(input string nm);
        int w;
        w = 0;
        while (!ready && w < 400) begin
            @(negedge clk);
            w++;
        end
        check({nm, "_wait"}, 32'(ready), 32'd1);
    endtask

    // Starts at the first negedge after an accept; returns at the negedge just past the frame.
    task automatic frame_check(input logic [23:0] exp, input string nm);
        logic [23:0]     word;
        logic [TBIT-1:0] pat;
        int bad, rdy_cnt, rdy_last;
        word = 24'd0; bad = 0; rdy_cnt = 0; rdy_last = 0;
        for (int b = 0; b < 24; b++) begin
            pat = '0;
            for (int c = 0; c < TBIT; c++) begin
                pat = {pat[TBIT-2:0], dout};
                if (ready) begin
                    rdy_cnt++;
                    if (b == 23 && c == TBIT - 1) rdy_last = 1;
                end
                @(negedge clk);
            end
            if (pat == PAT1)      word = {word[22:0], 1'b1};
            else if (pat == PAT0) word = {word[22:0], 1'b0};
            else begin
                word = {word[22:0], 1'b0};
                bad++;
            end
        end
        check({nm, "_pulse"}, 32'(bad), 32'd0);
        check({nm, "_word"}, 32'(word), 32'(exp));
        check({nm, "_ready_cnt"}, 32'(rdy_cnt), 32'd1);
        check({nm, "_ready_last"}, 32'(rdy_last), 32'd1);
    endtask

    task automatic latch_check(input string nm);
        int lows, bad;
        lows = 0; bad = 0;
        while (!ready && lows < 100) begin
            if (dout || !busy) bad++;
            lows++;
            @(negedge clk);
        end
        check({nm, "_latch_len"}, 32'(lows), 32'(TRESET));
        check({nm, "_latch_low"}, 32'(bad), 32'd0);
        check({nm, "_idle"}, 32'({ready, busy, dout}), 32'b100);
    endtask

    task automatic send(input logic [23:0] col, input logic [23:0] exp, input string nm);
        wait_ready(nm);
        valid  = 1'b1;
        colour = col;
        @(negedge clk);
        valid  = 1'b0;
        colour = ~col;
        frame_check(exp, nm);
        latch_check(nm);
    endtask

    initial begin
        vecs[0] = '{24'h0000FF, 24'h0000FF};
        vecs[1] = '{24'hFF0000, 24'h00FF00};
        vecs[2] = '{24'h00FF00, 24'hFF0000};
        vecs[3] = '{24'h123456, 24'h341256};
        vecs[4] = '{24'hA5C30F, 24'hC3A50F};
        vecs[5] = '{24'h800001, 24'h008001};

        repeat (3) @(negedge clk);
        check("rst_dout", 32'(dout), 32'd0);
        check("rst_ready", 32'(ready), 32'd0);
        check("rst_busy", 32'(busy), 32'd1);
        @(posedge clk);
        #1 rst = 1'b1;
        @(negedge clk);
        latch_check("por");

        foreach (vecs[i]) send(vecs[i].col, vecs[i].grb, $sformatf("vec%0d", i));

        // Reset in the middle of an all-ones frame.
        wait_ready("mid");
        valid  = 1'b1;
        colour = 24'hFFFFFF;
        @(negedge clk);
        valid = 1'b0;
        repeat (50) @(negedge clk);
        check("mid_pre_dout", 32'(dout), 32'd1);
        rst = 1'b0;
        #1;
        check("mid_rst_line", 32'({dout, ready, busy}), 32'b001);
        @(posedge clk);
        #1 rst = 1'b1;
        @(negedge clk);
        latch_check("mid_rst");

        // Chained frames: second accept on the last cycle of the first.
        wait_ready("chain");
        valid  = 1'b1;
        colour = 24'hFFFFFF;
        @(negedge clk);
        colour = 24'h000000;
        frame_check(24'hFFFFFF, "chain_a");
        valid  = 1'b0;
        colour = 24'h5A5A5A;
        frame_check(24'h000000, "chain_b");
        latch_check("chain");

        // valid held through LATCH; colour changed after each accept.
        wait_ready("hold");
        valid  = 1'b1;
        colour = 24'h00FF00;
        @(negedge clk);
        valid  = 1'b0;
        colour = 24'h0F0F0F;
        frame_check(24'hFF0000, "hold_a");
        valid  = 1'b1;
        colour = 24'h123456;
        latch_check("hold_latch");
        @(negedge clk);
        check("hold_accepted", 32'({busy, dout}), 32'b11);
        colour = 24'hDEAD00;
        valid  = 1'b0;
        frame_check(24'h341256, "hold_b");
        latch_check("hold_b");

        for (int i = 0; i < 100; i++) begin
            logic [23:0] c;
            c = 24'($urandom);
            send(c, model_grb(c), $sformatf("rand%0d", i));
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #5000000;
        $display("FAIL watchdog: simulation exceeded time limit (%0d/%0d checks passed)", n_pass, n_total);
        $fatal(1);
    end

endmodule
